lsu_ctrl: RTL

Load/store controller sitting between the decoder/datapath of the RV32 core and the data memory port. It turns a decoded memory instruction (`mem_req`, `mem_we`, `mem_size`, address, store data) into a req/gnt/rvalid bus transaction. It stalls the core until the transaction completes and returns byte-lane-formatted, sign/zero-extended load data. It also flags misaligned or illegal-size accesses and bus timeouts.

---
 rtl/lsu_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: turns decoded load/store instructions into req/gnt/rvalid bus transactions with stall, formatting and error reporting
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        legal, busy, tmo;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;
  assign legal = ((lsu_size_i == 3'b000) || (lsu_size_i == 3'b100))
               | (((lsu_size_i == 3'b001) || (lsu_size_i == 3'b101)) & ~lsu_addr_i[0])
               | ((lsu_size_i == 3'b010) & (lsu_addr_i[1:0] == 2'b00));
  assign busy = (state_q == REQ) || (state_q == RESP);
  assign tmo = (TIMEOUT_CYCLES != 0) && busy && (cnt_q == TO_LAST);
  assign ld_b = data_rdata_i[8*lsu_addr_i[1:0] +: 8];
  assign ld_h = data_rdata_i[16*lsu_addr_i[1] +: 16];
  assign ld_fmt = lsu_size_i[1] ? data_rdata_i
                : lsu_size_i[0] ? {{16{~lsu_size_i[2] & ld_h[15]}}, ld_h}
                : {{24{~lsu_size_i[2] & ld_b[7]}}, ld_b};
  assign lsu_data_o = data_q;
  assign lsu_stall_req_o = lsu_req_i & legal & (state_q != DONE);
  assign lsu_err_o = err_q | ((state_q == IDLE) & lsu_req_i & ~legal);
  assign data_req_o = ~rst_i & (((state_q == IDLE) & lsu_req_i & legal) | ((state_q == REQ) & ~tmo));
  assign data_we_o = lsu_we_i;
  assign data_be_o = lsu_size_i[1] ? 4'b1111 : (lsu_size_i[0] ? 4'b0011 : 4'b0001) << lsu_addr_i[1:0];
  assign data_addr_o = {lsu_addr_i[31:2], 2'b00};
  assign data_wdata_o = lsu_size_i[1] ? lsu_data_i
                      : lsu_size_i[0] ? {2{lsu_data_i[15:0]}}
                      : {4{lsu_data_i[7:0]}};
  // next state: advance the bus handshake, capture load data, abort on timeout
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    cnt_d = busy ? cnt_q + 16'd1 : 16'd0;
    err_d = tmo;
    unique case (state_q)
      IDLE: if (lsu_req_i && legal) state_d = data_gnt_i ? RESP : REQ;
      REQ:  state_d = tmo ? DONE : data_gnt_i ? RESP : REQ;
      RESP: begin
        state_d = (tmo || data_rvalid_i) ? DONE : RESP;
        data_d = (!tmo && data_rvalid_i && !lsu_we_i) ? ld_fmt : data_q;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // state, timeout counter, load result and timeout error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= 16'd0;
      data_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule
